lsu: RTL and testbench

- Load/store unit directly downstream of the control-signal decoder.
- Consumes the decoder's mem_rd_en, mem_wr_en and mem_op, plus the ALU-computed address and the rs2 store data.
- Runs one data-memory transaction per instruction over a valid/ready bus, with byte-lane steering, load extraction/extension, alignment checking and a response watchdog.
- Returns the load result (or completion of a non-memory instruction) to writeback through a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 23 ++
 rtl/lsu_align.sv | 63 ++++++
 rtl/lsu.sv | 153 +++++++++++++++
 tb/tb_lsu.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store encodings: mem_op widths, completion error codes and LSU FSM states.
// The control-signal decoder imports the same mem_op constants.
package lsu_pkg;

  localparam logic [2:0] OpB  = 3'b000;
  localparam logic [2:0] OpH  = 3'b001;
  localparam logic [2:0] OpW  = 3'b010;
  localparam logic [2:0] OpBu = 3'b100;
  localparam logic [2:0] OpHu = 3'b101;

  localparam logic [1:0] ErrNone     = 2'd0;
  localparam logic [1:0] ErrMisalign = 2'd1;
  localparam logic [1:0] ErrIllegal  = 2'd2;
  localparam logic [1:0] ErrBus      = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobes/replication, load extract/extend,
// and the illegal-op / misalignment classification of a memory instruction.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [1:0]  err
);

  logic [31:0] shifted;
  logic        legal_load;
  logic        legal_store;
  logic        misaligned;

  always_comb begin
    wstrb     = 4'b0000;
    wdata     = store_data;
    load_data = '0;
    shifted   = load_word >> {addr_lo, 3'b000};
    case (op)
      OpB: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      OpH: begin
        wstrb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      OpW: begin
        wstrb     = 4'b1111;
        load_data = shifted;
      end
      OpBu:    load_data = {24'd0, shifted[7:0]};
      OpHu:    load_data = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    legal_load  = op inside {OpB, OpH, OpW, OpBu, OpHu};
    legal_store = op inside {OpB, OpH, OpW};
    misaligned  = ((op[1:0] == 2'b01) && addr_lo[0]) || ((op[1:0] == 2'b10) && (addr_lo != 2'b00));
    err         = ErrNone;
    if (rd_en && wr_en) begin
      err = ErrIllegal;
    end else if ((rd_en && !legal_load) || (wr_en && !legal_store)) begin
      err = ErrIllegal;
    end else if ((rd_en || wr_en) && misaligned) begin
      err = ErrMisalign;
    end
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one decoded instruction, runs at most one data-memory
// transaction with a response watchdog, and hands the formatted result to writeback.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_rdata,
  output logic [1:0]        out_err,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_wen,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [31:0]       dmem_req_wdata,
  output logic [3:0]        dmem_req_wstrb,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rsp_rdata,
  input  logic              dmem_rsp_err
);

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic                rd_q, wr_q;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;

  logic                idle, req_active, accept;
  logic                al_rd, al_wr;
  logic [2:0]          al_op;
  logic [1:0]          al_addr_lo;
  logic [31:0]         al_store_data;
  logic [3:0]          al_wstrb;
  logic [31:0]         al_wdata, al_load_data;
  logic [1:0]          al_err;

  assign idle       = (state_q == StIdle);
  assign req_active = (state_q == StReq);
  assign accept     = idle && in_valid;

  // Classify the live instruction while idle; afterwards work from the latched copy.
  assign al_rd         = idle ? mem_rd_en  : rd_q;
  assign al_wr         = idle ? mem_wr_en  : wr_q;
  assign al_op         = idle ? mem_op     : op_q;
  assign al_addr_lo    = idle ? addr[1:0]  : addr_q[1:0];
  assign al_store_data = idle ? wdata      : wdata_q;

  lsu_align u_align (
    .rd_en      (al_rd),
    .wr_en      (al_wr),
    .op         (al_op),
    .addr_lo    (al_addr_lo),
    .store_data (al_store_data),
    .load_word  (dmem_rsp_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load_data),
    .err        (al_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= ErrNone;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        rd_q    <= mem_rd_en;
        wr_q    <= mem_wr_en;
        op_q    <= mem_op;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          rdata_d = '0;
          err_d   = al_err;
          state_d = (!(mem_rd_en || mem_wr_en) || (al_err != ErrNone)) ? StDone : StReq;
        end
      end
      StReq: begin
        if (dmem_req_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (dmem_rsp_valid) begin
          rdata_d = rd_q ? al_load_data : '0;
          if (dmem_rsp_err) err_d = ErrBus;
          state_d = StDone;
        end else if ((TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1))) begin
          rdata_d = '0;
          err_d   = ErrBus;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign in_ready       = idle;
  assign out_valid      = (state_q == StDone);
  assign out_rdata      = rdata_q;
  assign out_err        = err_q;
  assign dmem_req_valid = req_active;
  assign dmem_req_wen   = req_active && wr_q;
  assign dmem_req_addr  = req_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_req_wdata = req_active ? al_wdata : '0;
  assign dmem_req_wstrb = (req_active && wr_q) ? al_wstrb : 4'b0000;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized transactions
// compared against an arithmetic model of the load/store rules.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        mem_rd_en, mem_wr_en;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_wen;
  logic [31:0] dmem_req_addr, dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid, dmem_rsp_err;
  logic [31:0] dmem_rsp_rdata;

  int checks = 0;
  int errors = 0;

  lsu #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_rd_en      (mem_rd_en),
    .mem_wr_en      (mem_wr_en),
    .mem_op         (mem_op),
    .addr           (addr),
    .wdata          (wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_err        (out_err),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_req_wen   (dmem_req_wen),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_wstrb (dmem_req_wstrb),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .dmem_rsp_err   (dmem_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: access size in bytes, byte offset, sign rules, computed arithmetically.
  task automatic model(input logic rd, input logic wr, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] word, output logic [1:0] e,
                       output logic [3:0] strb, output logic [31:0] wd, output logic [31:0] rdat);
    int size, off, s;
    longint v;
    size = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    off  = int'(a % 4);
    e    = 2'd0;
    if (rd && wr) e = 2'd2;
    else if (rd && !(op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 2'd2;
    else if (wr && op > 3'd2) e = 2'd2;
    else if ((rd || wr) && (a % size) != 0) e = 2'd1;
    s    = ((1 << size) - 1) << off;
    strb = s[3:0];
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = sd[8*(i % size) +: 8];
    v = longint'(word >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
    if (!op[2] && size < 4 && v >= longint'(64'd1 << (8 * size - 1))) v = v - longint'(64'd1 << (8 * size));
    rdat = v[31:0];
  endtask

  task automatic run_txn(input string tag, input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] word,
                         input logic rsp_err, input int req_dly, input int rsp_dly,
                         input int out_dly, input logic early);
    logic [1:0]  e, exp_err;
    logic [3:0]  strb;
    logic [31:0] wd, rdat, exp_rdata;
    model(rd, wr, op, a, sd, word, e, strb, wd, rdat);
    chk({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1; mem_rd_en = rd; mem_wr_en = wr; mem_op = op; addr = a; wdata = sd;
    step();
    in_valid = 0; mem_rd_en = $urandom_range(0, 1); mem_wr_en = $urandom_range(0, 1);
    mem_op = 3'($urandom); addr = $urandom; wdata = $urandom;
    exp_err = e;
    exp_rdata = 32'd0;
    if (!(rd || wr) || e != 2'd0) begin
      chk({tag, ".nomem_req"}, dmem_req_valid, 0);
    end else begin
      for (int i = 0; i <= req_dly; i++) begin
        chk({tag, ".req_valid"}, dmem_req_valid, 1);
        chk({tag, ".req_addr"}, dmem_req_addr, {a[31:2], 2'b00});
        chk({tag, ".req_wen"}, dmem_req_wen, wr);
        chk({tag, ".req_wstrb"}, dmem_req_wstrb, wr ? strb : 4'b0000);
        if (wr) chk({tag, ".req_wdata"}, dmem_req_wdata, wd);
        chk({tag, ".req_outv"}, out_valid, 0);
        if (i == req_dly) begin
          dmem_req_ready = 1;
          if (early) begin dmem_rsp_valid = 1; dmem_rsp_rdata = $urandom; dmem_rsp_err = 1; end
        end
        step();
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_err = 0;
      end
      for (int i = 0; i <= rsp_dly; i++) begin
        chk({tag, ".wait_req"}, dmem_req_valid, 0);
        chk({tag, ".wait_outv"}, out_valid, 0);
        if (i == rsp_dly) begin
          dmem_rsp_valid = 1; dmem_rsp_rdata = word; dmem_rsp_err = rsp_err;
        end
        step();
        dmem_rsp_valid = 0; dmem_rsp_err = 0; dmem_rsp_rdata = $urandom;
      end
      exp_err   = rsp_err ? 2'd3 : 2'd0;
      exp_rdata = rd ? rdat : 32'd0;
    end
    for (int i = 0; i <= out_dly; i++) begin
      chk({tag, ".out_valid"}, out_valid, 1);
      chk({tag, ".out_err"}, out_err, exp_err);
      chk({tag, ".out_rdata"}, out_rdata, exp_rdata);
      chk({tag, ".done_in_ready"}, in_ready, 0);
      if (i == out_dly) out_ready = 1;
      step();
      out_ready = 0;
    end
    chk({tag, ".after_outv"}, out_valid, 0);
    chk({tag, ".after_in_ready"}, in_ready, 1);
  endtask

  // Accept a lw and leave the DUT in REQ (to_wait=0) or WAIT (to_wait=1).
  task automatic start_lw(input logic [31:0] a, input logic to_wait);
    in_valid = 1; mem_rd_en = 1; mem_wr_en = 0; mem_op = 3'b010; addr = a;
    step();
    in_valid = 0; mem_rd_en = 0;
    chk("start.req_valid", dmem_req_valid, 1);
    if (to_wait) begin
      dmem_req_ready = 1;
      step();
      dmem_req_ready = 0;
    end
  endtask

  task automatic async_reset(input string tag);
    rst = 1;
    #1;
    chk({tag, ".req_valid"}, dmem_req_valid, 0);
    chk({tag, ".req_addr"}, dmem_req_addr, 0);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".out_err"}, out_err, 0);
    chk({tag, ".in_ready"}, in_ready, 1);
    step();
    rst = 0;
  endtask

  initial begin
    logic       rd, wr;
    logic [2:0] op;
    logic [31:0] a;
    int kind;
    rst = 1; in_valid = 0; mem_rd_en = 0; mem_wr_en = 0; mem_op = 0; addr = 0; wdata = 0;
    out_ready = 0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0; dmem_rsp_err = 0;
    #3;
    chk("reset.in_ready", in_ready, 1);
    chk("reset.out_valid", out_valid, 0);
    chk("reset.req_valid", dmem_req_valid, 0);
    chk("reset.out_err", out_err, 0);
    chk("reset.out_rdata", out_rdata, 0);
    step();
    rst = 0;
    step();

    run_txn("lw", 1, 0, 3'b010, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    run_txn("lb", 1, 0, 3'b000, 32'h8000_0003, 0, 32'h80FF_0000, 0, 0, 0, 0, 0);
    run_txn("lbu", 1, 0, 3'b100, 32'h8000_0003, 0, 32'h80FF_0000, 0, 0, 1, 0, 0);
    run_txn("lh", 1, 0, 3'b001, 32'h8000_0002, 0, 32'h80FF_0000, 0, 1, 0, 0, 1);
    run_txn("lhu", 1, 0, 3'b101, 32'h8000_0002, 0, 32'h80FF_0000, 0, 0, 2, 1, 0);
    run_txn("sh", 0, 1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 3, 0, 0, 0);
    run_txn("sb", 0, 1, 3'b000, 32'h8000_0001, 32'h0000_005A, 32'h0, 0, 0, 0, 0, 0);
    run_txn("lw_mis", 1, 0, 3'b010, 32'h8000_0001, 0, 0, 0, 0, 0, 0, 0);
    run_txn("both_en", 1, 1, 3'b010, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0);
    run_txn("st_ill", 0, 1, 3'b100, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0);
    run_txn("ld_ill", 1, 0, 3'b111, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0);
    run_txn("nomem", 0, 0, 3'b010, 32'h8000_0001, 0, 0, 0, 0, 0, 1, 0);
    run_txn("bus_err", 1, 0, 3'b010, 32'h8000_0010, 0, 32'h0BAD_F00D, 1, 0, 3, 0, 0);

    // Watchdog: no response, timeout after four WAIT cycles; a late response is ignored.
    start_lw(32'h8000_0008, 1);
    for (int i = 0; i < 4; i++) begin
      chk("to.wait_outv", out_valid, 0);
      step();
    end
    chk("to.out_valid", out_valid, 1);
    chk("to.out_err", out_err, 3);
    chk("to.out_rdata", out_rdata, 0);
    out_ready = 1;
    step();
    out_ready = 0;
    chk("to.idle", in_ready, 1);
    dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h1111_2222;
    step();
    dmem_rsp_valid = 0;
    chk("late_rsp.out_valid", out_valid, 0);
    chk("late_rsp.in_ready", in_ready, 1);

    start_lw(32'h8000_0020, 1);
    async_reset("rst_wait");
    start_lw(32'h8000_0024, 0);
    async_reset("rst_req");
    run_txn("sw_after_rst", 0, 1, 3'b010, 32'h8000_000C, 32'hCAFE_F00D, 0, 0, 1, 1, 5, 0);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      rd = (kind == 1) || (kind >= 2 && kind <= 5);
      wr = (kind == 1) || (kind >= 6);
      op = 3'($urandom);
      if ($urandom_range(0, 1) == 1) op = rd ? 3'($urandom_range(0, 2)) | 3'($urandom_range(0, 1) << 2) : 3'($urandom_range(0, 2));
      if (op == 3'b110) op = 3'b010;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn("rnd", rd, wr, op, a, $urandom, $urandom, ($urandom_range(0, 7) == 0),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
